down_counter_sequencer: RTL and testbench
=========================================

// Module: down_counter_sequencer
// PURPOSE
//  Loadable down-counter with a sequencing FSM: it issues N step requests to a datapath and finishes with a
//  one-cycle done pulse. It is the consuming end of the up-counter/carry-out scheme.
//  The up-counter counts from a preset toward all-ones. This block loads an iteration count and consumes it
//  one step at a time, down to zero.
//  It sits in the controller, between the top-level start logic and the iterating datapath.
// PARAMETERS
//  WIDTH   4    counter width in bits
//  INIT    14   default iteration count, loaded when use_load=0; must satisfy 0 <= INIT <= 2**WIDTH-1
// PORTS
//  clk        in   1      clock, rising edge
//  sclr       in   1      reset sclr, asynchronous, active-high
//  start      in   1      begin a run; sampled in IDLE only
//  use_load   in   1      1: load load_val on start; 0: load INIT
//  load_val   in   WIDTH  iteration count used when use_load=1
//  abort      in   1      synchronous abort of a run in progress
//  step_ack   in   1      datapath has accepted the current step
//  step_req   out  1      step request to the datapath (registered)
//  busy       out  1      1 in RUN state
//  done       out  1      one-cycle pulse when a run completes normally
//  bo         out  1      borrow-out: cnt_val == 0 (combinational)
//  cnt_val    out  WIDTH  remaining iterations
// BEHAVIOUR
//  - Reset (sclr=1, any time, including mid-run):
//    state=IDLE, cnt_val=0, step_req=0, busy=0, done=0, so bo=1. No done pulse is produced.
//  - States: IDLE, RUN, DONE. Transitions occur on the rising edge of clk.
//  - IDLE, start=0: no change; cnt_val holds.
//  - IDLE, start=1, loaded value V (V = use_load ? load_val : INIT):
//    - cnt_val <= V.
//    - V==0: go to DONE; step_req stays 0 (zero-length run).
//    - V!=0: go to RUN; step_req=1 and busy=1 from the next cycle.
//  - RUN, one step: a step completes on a cycle where step_req=1 and step_ack=1. Then cnt_val <= cnt_val-1.
//  - RUN, last step: a completing step with cnt_val==1 moves to DONE.
//    In DONE, step_req=0, busy=0 and cnt_val=0.
//  - RUN, no ack: step_ack=0 holds cnt_val and step_req (no timeout).
//  - step_ack while step_req=0 is ignored.
//  - Handshake: step_req stays high back-to-back while steps remain. Exactly V steps complete per run.
//  - DONE: done=1 for exactly one cycle, then return to IDLE. start in the DONE cycle is ignored.
//  - abort=1 in RUN: go to IDLE next cycle with step_req=0 and busy=0. No done pulse; cnt_val holds.
//    abort wins over a simultaneous step_ack (no decrement).
//  - abort is ignored in IDLE and DONE.
//  - start while busy: ignored, no reload.
//  - Arithmetic: decrement is modulo 2**WIDTH, but the FSM never decrements at 0, so no wrap occurs.
//  - Latency:
//    - start -> first step_req: 1 cycle.
//    - last ack -> done: 1 cycle.
//    - Minimum run of V steps with ack tied high: V+2 cycles, start edge to done deasserting.
// CONFIGURATION
//  DOWN_CNT_PAUSE_EN defined:
//    - Adds input port pause (1 bit), placed after abort.
//    - In RUN, pause=1 forces step_req=0 on the next cycle and blocks decrement; state stays RUN.
//    - step_req resumes the cycle after pause falls.
//    - abort and sclr override pause.
//  DOWN_CNT_PAUSE_EN not defined: no pause port; RUN behaves as described above.
// TESTING
//  1. sclr pulse mid-run with cnt_val=5 -> same cycle: cnt_val=0, bo=1, step_req=0, busy=0; no done.
//  2. use_load=0, start, step_ack tied 1 -> 14 step_req cycles; cnt_val 14..1; done one cycle later, cnt_val=0.
//  3. use_load=1, load_val=3, step_ack high only every other cycle -> exactly 3 decrements (3,2,1,0); done once.
//  4. use_load=1, load_val=0, start -> step_req never asserts; done pulses 1 cycle after start; back in IDLE.
//  5. load_val=6; after 2 acks, abort and step_ack together -> cnt_val stays 4, IDLE, no done.
//     Then start again -> reloads 6.
//  6. start held high throughout a run of 2 -> no reload while busy; after done, a new run starts from IDLE.
//     DOWN_CNT_PAUSE_EN build: pause 3 cycles mid-run -> no decrement, step_req=0, resumes afterwards.

Source files
------------

// File: rtl/down_counter_sequencer.sv
// -----------------------------------------------------------------------------
// down_counter_sequencer
//
// Loadable down-counter with a sequencing FSM. A run loads an iteration count V.
// The block then issues V step requests to a datapath, one per step_ack, and
// ends with a one-cycle done pulse. This block consumes the iteration count.
// The matching up-counter produces it.
//
// Configuration macro: DOWN_CNT_PAUSE_EN
//   When defined, the block has a pause input. While pause is high in RUN,
//   step_req is held low and the count does not change.
//
// Parameters
//   WIDTH     counter width in bits
//   INIT      iteration count loaded when use_load=0 (0 .. 2**WIDTH-1)
//
// Ports
//   clk       clock, rising edge
//   sclr      asynchronous active-high reset
//   start     begin a run (sampled in IDLE only)
//   use_load  1: load load_val on start, 0: load INIT
//   load_val  iteration count used when use_load=1
//   abort     synchronous abort of a run in progress
//   pause     (DOWN_CNT_PAUSE_EN only) stall the run without leaving RUN
//   step_ack  datapath accepted the current step
//   step_req  registered step request to the datapath
//   busy      high in RUN
//   done      one-cycle pulse when a run completes normally
//   bo        borrow-out, cnt_val == 0
//   cnt_val   remaining iterations
// -----------------------------------------------------------------------------
module down_counter_sequencer #(
    parameter int WIDTH = 4,
    parameter int INIT  = 14
) (
    input  logic             clk,
    input  logic             sclr,
    input  logic             start,
    input  logic             use_load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             abort,
`ifdef DOWN_CNT_PAUSE_EN
    input  logic             pause,
`endif
    input  logic             step_ack,
    output logic             step_req,
    output logic             busy,
    output logic             done,
    output logic             bo,
    output logic [WIDTH-1:0] cnt_val
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [WIDTH-1:0] INIT_VAL = WIDTH'(INIT);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             step_req_q, step_req_d;
    logic [WIDTH-1:0] load_v;
    logic             pause_i;
    logic             step_done;

`ifdef DOWN_CNT_PAUSE_EN
    assign pause_i = pause;
`else
    assign pause_i = 1'b0;
`endif

    assign load_v = use_load ? load_val : INIT_VAL;

    // A step completes only while a request is outstanding. A pause in the
    // same cycle blocks it, so an ack given during a pause is not counted.
    assign step_done = step_req_q && step_ack && !pause_i;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        step_req_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cnt_d = load_v;
                    if (load_v == '0) begin
                        state_d = ST_DONE;     // zero-length run: no steps at all
                    end else begin
                        state_d    = ST_RUN;
                        step_req_d = 1'b1;
                    end
                end
            end

            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;         // cnt_val holds the remaining count
                end else if (pause_i) begin
                    step_req_d = 1'b0;
                end else if (step_done) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == WIDTH'(1)) begin
                        state_d = ST_DONE;
                    end else begin
                        step_req_d = 1'b1;     // back-to-back requests
                    end
                end else begin
                    step_req_d = 1'b1;         // hold, or resume after a pause
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; blocking here would race readers.
    always_ff @(posedge clk or posedge sclr) begin
        if (sclr) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            step_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            step_req_q <= step_req_d;
        end
    end

    assign step_req = step_req_q;
    assign busy     = (state_q == ST_RUN);
    assign done     = (state_q == ST_DONE);
    assign cnt_val  = cnt_q;
    assign bo       = (cnt_q == '0);

endmodule

// File: tb/tb_down_counter_sequencer.sv
// -----------------------------------------------------------------------------
// tb_down_counter_sequencer
//
// Directed self-checking bench for down_counter_sequencer (WIDTH=4, INIT=14).
// Inputs change 1 time unit after a rising edge. Outputs are sampled at the
// same point, away from the edge. Expected values are written out by hand.
// -----------------------------------------------------------------------------
module tb_down_counter_sequencer;

    localparam int WIDTH = 4;
    localparam int INIT  = 14;

    logic             clk;
    logic             sclr;
    logic             start;
    logic             use_load;
    logic [WIDTH-1:0] load_val;
    logic             abort;
    logic             pause;
    logic             step_ack;
    logic             step_req;
    logic             busy;
    logic             done;
    logic             bo;
    logic [WIDTH-1:0] cnt_val;

    int n_checks = 0;
    int n_errors = 0;

    down_counter_sequencer #(
        .WIDTH(WIDTH),
        .INIT (INIT)
    ) dut (
        .clk     (clk),
        .sclr    (sclr),
        .start   (start),
        .use_load(use_load),
        .load_val(load_val),
        .abort   (abort),
`ifdef DOWN_CNT_PAUSE_EN
        .pause   (pause),
`endif
        .step_ack(step_ack),
        .step_req(step_req),
        .busy    (busy),
        .done    (done),
        .bo      (bo),
        .cnt_val (cnt_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag, input int unsigned exp_cnt);
        check({tag, " busy"}, busy, 0);
        check({tag, " step_req"}, step_req, 0);
        check({tag, " done"}, done, 0);
        check({tag, " cnt"}, cnt_val, exp_cnt);
    endtask

    // Alternating-ack run of 3: ack per cycle, expected count and done after it.
    int ack_v [6] = '{0, 1, 0, 1, 0, 1};
    int cnt_v [6] = '{3, 2, 2, 1, 1, 0};
    int done_v[6] = '{0, 0, 0, 0, 0, 1};

    initial begin
        int done_cnt;

        sclr     = 1'b1;
        start    = 1'b0;
        use_load = 1'b0;
        load_val = '0;
        abort    = 1'b0;
        pause    = 1'b0;
        step_ack = 1'b0;
        tick();
        tick();

        // Reset state.
        check_idle("reset", 0);
        check("reset bo", bo, 1);
        sclr = 1'b0;
        tick();
        check_idle("post_reset", 0);

        // Default INIT run, ack tied high: 14 requests, count 14..1, then done.
        use_load = 1'b0;
        start    = 1'b1;
        step_ack = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 14; i >= 1; i--) begin
            check($sformatf("init_run cnt%0d", i), cnt_val, i);
            check($sformatf("init_run req%0d", i), step_req, 1);
            check($sformatf("init_run busy%0d", i), busy, 1);
            check($sformatf("init_run done%0d", i), done, 0);
            check($sformatf("init_run bo%0d", i), bo, 0);
            tick();
        end
        check("init_run done", done, 1);
        check("init_run end cnt", cnt_val, 0);
        check("init_run end req", step_req, 0);
        check("init_run end busy", busy, 0);
        check("init_run end bo", bo, 1);
        step_ack = 1'b0;
        tick();
        check_idle("init_run idle", 0);

        // load_val=3, ack every other cycle: 3,2,1,0 and a single done pulse.
        use_load = 1'b1;
        load_val = 4'd3;
        start    = 1'b1;
        tick();
        start = 1'b0;
        check("alt load cnt", cnt_val, 3);
        check("alt load req", step_req, 1);
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step_ack = ack_v[i][0];
            tick();
            check($sformatf("alt cnt[%0d]", i), cnt_val, cnt_v[i]);
            check($sformatf("alt done[%0d]", i), done, done_v[i]);
            if (done) done_cnt++;
        end
        step_ack = 1'b0;
        tick();
        if (done) done_cnt++;
        check("alt done count", done_cnt, 1);
        check_idle("alt idle", 0);

        // Zero-length run: no request, done one cycle after start.
        load_val = 4'd0;
        step_ack = 1'b1;
        start    = 1'b1;
        tick();
        start = 1'b0;
        check("zero done", done, 1);
        check("zero req", step_req, 0);
        check("zero busy", busy, 0);
        check("zero cnt", cnt_val, 0);
        tick();
        check_idle("zero idle", 0);
        step_ack = 1'b0;

        // Abort after two acks with a simultaneous ack: count holds at 4.
        load_val = 4'd6;
        step_ack = 1'b1;
        start    = 1'b1;
        tick();
        start = 1'b0;
        check("abort load cnt", cnt_val, 6);
        tick();
        check("abort ack1 cnt", cnt_val, 5);
        tick();
        check("abort ack2 cnt", cnt_val, 4);
        abort = 1'b1;
        tick();
        abort    = 1'b0;
        step_ack = 1'b0;
        check_idle("abort", 4);
        tick();
        check_idle("abort hold", 4);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("abort reload cnt", cnt_val, 6);
        check("abort reload busy", busy, 1);
        abort = 1'b1;   // also checks that abort in IDLE on the next edge is harmless
        tick();
        tick();
        abort = 1'b0;
        check_idle("abort clean", 6);

        // sclr mid-run at cnt=5: outputs clear immediately, no done afterwards.
        load_val = 4'd7;
        step_ack = 1'b1;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        step_ack = 1'b0;
        check("sclr pre cnt", cnt_val, 5);
        sclr = 1'b1;
        #1;
        check_idle("sclr async", 0);
        check("sclr async bo", bo, 1);
        tick();
        sclr = 1'b0;
        tick();
        check_idle("sclr after", 0);

        // start held high over a run of 2: no reload while busy, restart from IDLE.
        load_val = 4'd2;
        step_ack = 1'b1;
        start    = 1'b1;
        tick();
        check("held cnt2", cnt_val, 2);
        check("held busy2", busy, 1);
        tick();
        check("held cnt1", cnt_val, 1);
        tick();
        check("held done", done, 1);
        check("held done cnt", cnt_val, 0);
        tick();
        check_idle("held idle", 0);
        tick();
        check("held restart cnt", cnt_val, 2);
        check("held restart busy", busy, 1);
        start    = 1'b0;
        step_ack = 1'b0;
        abort    = 1'b1;
        tick();
        abort = 1'b0;
        check_idle("held clean", 2);

`ifdef DOWN_CNT_PAUSE_EN
        // Pause three cycles mid-run: request drops, count frozen, then resumes.
        load_val = 4'd5;
        step_ack = 1'b1;
        start    = 1'b1;
        tick();
        start = 1'b0;
        check("pause load cnt", cnt_val, 5);
        tick();
        check("pause pre cnt", cnt_val, 4);
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("pause req%0d", i), step_req, 0);
            check($sformatf("pause cnt%0d", i), cnt_val, 4);
            check($sformatf("pause busy%0d", i), busy, 1);
        end
        pause = 1'b0;
        tick();
        check("pause resume req", step_req, 1);
        check("pause resume cnt", cnt_val, 4);
        tick();
        check("pause step cnt", cnt_val, 3);
        step_ack = 1'b0;
        abort    = 1'b1;
        tick();
        abort = 1'b0;
        check_idle("pause clean", 3);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
